keystream_packer: RTL and testbench

KEYSTREAM_PACKER -- requirements
Module: keystream_packer

---
 rtl/keystream_packer.sv | 126 ++++++++++++
 tb/tb_keystream_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystream_packer.sv
`default_nettype none
// ============================================================================
// Module      : keystream_packer
// Description : Discards a warm-up run of serial keystream bits, then packs
//               the following bits into bytes behind a one-deep holding stage.
// Revision    : 1.0 - initial release
// ============================================================================
module keystream_packer #(
    parameter int WARMUP_BITS = 1152,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       restart,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       keystream_read,
    output logic [7:0] keystream_byte,
    output logic       keystream_valid,
    output logic       warmup_done
);

    localparam int C_WCW = ($clog2(WARMUP_BITS + 1) > 0) ? $clog2(WARMUP_BITS + 1) : 1;
    localparam logic [C_WCW-1:0] C_WARM_LAST = C_WCW'(WARMUP_BITS);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_PACK   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [C_WCW-1:0]   r_warm_cnt;
    logic [C_WCW-1:0]   w_warm_inc;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_asm;
    logic [7:0]         w_asm_next;
    logic [7:0]         r_byte;
    logic               r_valid;
    logic               r_done;
    logic               w_bit_ready;
    logic               w_xfer;
    logic               w_read;
    logic               w_complete;
    logic               w_warm_exit;

    // The 8th bit of a byte may only be taken when the holding stage frees up.
    assign w_bit_ready = ena && (r_state == ST_WARMUP || r_bit_cnt != 3'd7 ||
                                 !r_valid || keystream_read);
    assign w_xfer      = bit_valid && w_bit_ready;
    assign w_read      = ena && keystream_read && r_valid;
    assign w_complete  = (r_state == ST_PACK) && w_xfer && (r_bit_cnt == 3'd7);
    assign w_warm_inc  = r_warm_cnt + C_WCW'(1);
    assign w_warm_exit = (WARMUP_BITS == 0) ? ena : (w_xfer && (w_warm_inc == C_WARM_LAST));

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_asm_next = {bit_in, r_asm[7:1]};
        end else begin : g_msb_first
            assign w_asm_next = {r_asm[6:0], bit_in};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        if (restart) begin
            w_state_next = ST_WARMUP;
        end else if (r_state == ST_WARMUP && w_warm_exit) begin
            w_state_next = ST_PACK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_WARMUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_asm      <= 8'h00;
            r_byte     <= 8'h00;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else if (restart) begin
            // A held byte belongs to the old key and is dropped.
            r_warm_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_asm      <= 8'h00;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (r_state == ST_WARMUP) begin
                if (w_warm_exit) begin
                    r_done     <= 1'b1;
                    r_warm_cnt <= '0;
                end else if (w_xfer) begin
                    r_warm_cnt <= w_warm_inc;
                end
            end else if (w_xfer) begin
                r_asm     <= w_asm_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_complete) begin
                r_byte  <= w_asm_next;
                r_valid <= 1'b1;
            end else if (w_read) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bit_ready       = w_bit_ready;
    assign keystream_byte  = r_byte;
    assign keystream_valid = r_valid;
    assign warmup_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_keystream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_keystream_packer
// Description : Directed self-checking bench for keystream_packer (16-bit
//               warm-up, LSB-first main instance plus an MSB-first twin).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keystream_packer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       restart;
    logic       bit_in;
    logic       bit_valid;
    logic       keystream_read;
    logic       bit_ready;
    logic [7:0] keystream_byte;
    logic       keystream_valid;
    logic       warmup_done;
    logic       bit_ready_m;
    logic [7:0] keystream_byte_m;
    logic       keystream_valid_m;
    logic       warmup_done_m;

    int checks;
    int failures;

    keystream_packer #(.WARMUP_BITS(16), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .restart(restart),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .keystream_read(keystream_read), .keystream_byte(keystream_byte),
        .keystream_valid(keystream_valid), .warmup_done(warmup_done)
    );

    keystream_packer #(.WARMUP_BITS(16), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .ena(ena), .restart(restart),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_m),
        .keystream_read(keystream_read), .keystream_byte(keystream_byte_m),
        .keystream_valid(keystream_valid_m), .warmup_done(warmup_done_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
    endtask

    function automatic logic [7:0] reverse8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; restart = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; keystream_read = 1'b0;
        step(); step();
        checks++;
        if (keystream_valid !== 1'b0 || keystream_byte !== 8'h00 || warmup_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b byte=%h done=%b, expected 0/00/0",
                     keystream_valid, keystream_byte, warmup_done);
        end
        checks++;
        if (bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: bit_ready=%b, expected 1", bit_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        checks++;
        if (warmup_done !== 1'b0) begin
            failures++;
            $display("FAIL warmup_early: done=%b after 15 bits, expected 0", warmup_done);
        end
        send_bit(1'b1);
        checks++;
        if (warmup_done !== 1'b1 || keystream_valid !== 1'b0) begin
            failures++;
            $display("FAIL warmup_done: done=%b valid=%b after 16 bits, expected 1/0",
                     warmup_done, keystream_valid);
        end
    endtask

    task automatic test_pack_byte();
        logic [7:0] seq;
        seq = 8'b1000_0101;   // seq[i] is the i-th bit sent: 1,0,1,0,0,0,0,1
        for (int i = 0; i < 7; i++) send_bit(seq[i]);
        checks++;
        if (keystream_valid !== 1'b0) begin
            failures++;
            $display("FAIL pack_early: valid=%b after 7 bits, expected 0", keystream_valid);
        end
        send_bit(seq[7]);
        checks++;
        if (keystream_valid !== 1'b1 || keystream_byte !== 8'h85) begin
            failures++;
            $display("FAIL pack_lsb: valid=%b byte=%h, expected 1/85", keystream_valid, keystream_byte);
        end
        checks++;
        if (keystream_valid_m !== 1'b1 || keystream_byte_m !== 8'hA1) begin
            failures++;
            $display("FAIL pack_msb: valid=%b byte=%h, expected 1/a1", keystream_valid_m, keystream_byte_m);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] data;
        data = 8'h13;
        for (int i = 0; i < 7; i++) send_bit(data[i]);
        checks++;
        if (bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_drop: bit_ready=%b after 7 bits with full hold, expected 0", bit_ready);
        end
        bit_in = data[7]; bit_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bit_ready !== 1'b0 || keystream_valid !== 1'b1 || keystream_byte !== 8'h85) begin
                failures++;
                $display("FAIL bp_hold: ready=%b valid=%b byte=%h, expected 0/1/85",
                         bit_ready, keystream_valid, keystream_byte);
            end
        end
        bit_valid = 1'b0; keystream_read = 1'b1;
        step();
        keystream_read = 1'b0;
        checks++;
        if (keystream_valid !== 1'b0 || keystream_byte !== 8'h85 || bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_read: valid=%b byte=%h ready=%b, expected 0/85/1",
                     keystream_valid, keystream_byte, bit_ready);
        end
        send_bit(data[7]);
        checks++;
        if (keystream_valid !== 1'b1 || keystream_byte !== 8'h13 || keystream_byte_m !== 8'hC8) begin
            failures++;
            $display("FAIL bp_resume: valid=%b byte=%h msb=%h, expected 1/13/c8",
                     keystream_valid, keystream_byte, keystream_byte_m);
        end
        keystream_read = 1'b1; step(); step(); keystream_read = 1'b0;
        checks++;
        if (keystream_valid !== 1'b0 || keystream_byte !== 8'h13) begin
            failures++;
            $display("FAIL read_empty: valid=%b byte=%h, expected 0/13", keystream_valid, keystream_byte);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [3];
        data[0] = 8'h12; data[1] = 8'hC7; data[2] = 8'h6B;
        send_byte(data[0]);
        checks++;
        if (keystream_valid !== 1'b1 || keystream_byte !== data[0]) begin
            failures++;
            $display("FAIL b2b_first: valid=%b byte=%h, expected 1/%h", keystream_valid, keystream_byte, data[0]);
        end
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                bit_in = data[k][i]; bit_valid = 1'b1;
                keystream_read = (i == 7);
                step();
                checks++;
                if (keystream_valid !== 1'b1 || keystream_byte !== ((i == 7) ? data[k] : data[k-1])) begin
                    failures++;
                    $display("FAIL b2b_stream: byte %0d bit %0d valid=%b byte=%h, expected 1/%h",
                             k, i, keystream_valid, keystream_byte, (i == 7) ? data[k] : data[k-1]);
                end
            end
            checks++;
            if (keystream_byte_m !== reverse8(data[k])) begin
                failures++;
                $display("FAIL b2b_msb: byte=%h, expected %h", keystream_byte_m, reverse8(data[k]));
            end
        end
        bit_valid = 1'b0; keystream_read = 1'b0;
    endtask

    task automatic test_restart();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        restart = 1'b1; step(); restart = 1'b0;
        checks++;
        if (keystream_valid !== 1'b0 || warmup_done !== 1'b0 || bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: valid=%b done=%b ready=%b, expected 0/0/1",
                     keystream_valid, warmup_done, bit_ready);
        end
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        checks++;
        if (warmup_done !== 1'b0) begin
            failures++;
            $display("FAIL restart_warm_early: done=%b, expected 0", warmup_done);
        end
        send_bit(1'b1);
        checks++;
        if (warmup_done !== 1'b1 || keystream_valid !== 1'b0) begin
            failures++;
            $display("FAIL restart_warm_done: done=%b valid=%b, expected 1/0", warmup_done, keystream_valid);
        end
        send_byte(8'h12);
        checks++;
        if (keystream_valid !== 1'b1 || keystream_byte !== 8'h12 || keystream_byte_m !== 8'h48) begin
            failures++;
            $display("FAIL restart_byte: valid=%b byte=%h msb=%h, expected 1/12/48",
                     keystream_valid, keystream_byte, keystream_byte_m);
        end
    endtask

    task automatic test_enable_and_reset();
        logic [7:0] data;
        data = 8'hC7;
        keystream_read = 1'b1; step(); keystream_read = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(data[i]);
        ena = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; keystream_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bit_ready !== 1'b0 || keystream_valid !== 1'b0) begin
                failures++;
                $display("FAIL ena_freeze: ready=%b valid=%b, expected 0/0", bit_ready, keystream_valid);
            end
        end
        ena = 1'b1; bit_valid = 1'b0; keystream_read = 1'b0;
        for (int i = 4; i < 8; i++) send_bit(data[i]);
        checks++;
        if (keystream_valid !== 1'b1 || keystream_byte !== 8'hC7) begin
            failures++;
            $display("FAIL ena_resume: valid=%b byte=%h, expected 1/c7", keystream_valid, keystream_byte);
        end
        ena = 1'b0; keystream_read = 1'b1; step(); ena = 1'b1; keystream_read = 1'b0;
        checks++;
        if (keystream_valid !== 1'b1) begin
            failures++;
            $display("FAIL ena_read_ignored: valid=%b, expected 1", keystream_valid);
        end
        restart = 1'b1; step(); restart = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        ena = 1'b0; restart = 1'b1; rst_n = 1'b0;
        step();
        checks++;
        if (keystream_valid !== 1'b0 || keystream_byte !== 8'h00 || warmup_done !== 1'b0 ||
            keystream_byte_m !== 8'h00) begin
            failures++;
            $display("FAIL midreset: valid=%b byte=%h done=%b msb=%h, expected 0/00/0/00",
                     keystream_valid, keystream_byte, warmup_done, keystream_byte_m);
        end
        rst_n = 1'b1; ena = 1'b1; restart = 1'b0;
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        checks++;
        if (warmup_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_warm_early: done=%b, expected 0", warmup_done);
        end
        send_bit(1'b1);
        checks++;
        if (warmup_done !== 1'b1) begin
            failures++;
            $display("FAIL midreset_warm_done: done=%b, expected 1", warmup_done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_warmup();
        test_pack_byte();
        test_backpressure();
        test_back_to_back();
        test_restart();
        test_enable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
